// File: rtl/gearbox_1_to_n_pkg.sv
// Shared helpers for the 1:N width-up gearbox.
// lane_mask() is only called when GEARBOX_1_TO_N_LAST_EN is defined.
package gearbox_pkg;

    // Largest N that lane_mask() can describe.
    localparam int MAX_N = 32;

    // Width of the lane counter: enough to hold 0..n-1, never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Keep vector for a beat that closes on lane cnt.
    // Bit n-1 is lane 0, so lanes 0..cnt map to bits n-1 down to n-1-cnt.
    function automatic logic [MAX_N-1:0] lane_mask(input int cnt, input int n);
        logic [MAX_N-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if ((i < n) && (i >= n - 1 - cnt)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/gearbox_1_to_n_if.sv
// Bus bundle for gearbox_1_to_n: a narrow upstream word channel and a wide
// downstream beat channel. up_last/down_keep exist only when
// GEARBOX_1_TO_N_LAST_EN is defined.
//
// Handshake rule on both channels: a transfer happens on a rising clk edge
// where vld and rdy are both 1. A source holds vld and its payload steady
// until that transfer. rdy may depend combinationally on the sink's own
// downstream rdy, but never on the vld arriving at that sink.
interface gearbox_1_to_n_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    logic                 up_vld;
    logic                 up_rdy;
    logic [WIDTH-1:0]     up_data;
    logic                 down_vld;
    logic                 down_rdy;
    logic [N*WIDTH-1:0]   down_data;
`ifdef GEARBOX_1_TO_N_LAST_EN
    logic                 up_last;
    logic [N-1:0]         down_keep;
`endif

    // Gearbox side of the bundle.
    modport slave (
        input  up_vld,
        input  up_data,
        input  down_rdy,
`ifdef GEARBOX_1_TO_N_LAST_EN
        input  up_last,
        output down_keep,
`endif
        output up_rdy,
        output down_vld,
        output down_data
    );

    // Environment side: the producer and the consumer together.
    modport master (
        output up_vld,
        output up_data,
        output down_rdy,
`ifdef GEARBOX_1_TO_N_LAST_EN
        output up_last,
        input  down_keep,
`endif
        input  up_rdy,
        input  down_vld,
        input  down_data
    );
endinterface

// File: rtl/gearbox_out_reg.sv
// Output holding register for the gearbox. It holds one packed beat with its
// valid flag (and its keep mask when GEARBOX_1_TO_N_LAST_EN is defined). It
// also produces the upstream ready: the register can take a new beat when it
// is empty or when its current beat leaves this cycle.
module gearbox_out_reg #(
    parameter int DATA_W = 32,
    parameter int KEEP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
`ifdef GEARBOX_1_TO_N_LAST_EN
    input  logic [KEEP_W-1:0] load_keep,
    output logic [KEEP_W-1:0] keep,
`endif
    input  logic              rdy,
    output logic              vld,
    output logic [DATA_W-1:0] data,
    output logic              up_rdy
);

    // Space is free when empty or when the held beat drains on this edge.
    assign up_rdy = ~vld | rdy;

    // A load wins over a drain, so a beat arriving as the old one leaves keeps vld high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= 1'b0;
            data <= '0;
`ifdef GEARBOX_1_TO_N_LAST_EN
            keep <= '0;
`endif
        end else if (load) begin
            vld  <= 1'b1;
            data <= load_data;
`ifdef GEARBOX_1_TO_N_LAST_EN
            keep <= load_keep;
`endif
        end else if (rdy) begin
            vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/gearbox_1_to_n.sv
// 1:N width-up gearbox. It packs N WIDTH-bit words into one N*WIDTH-bit beat.
// The first word of a beat lands in the MSBs.
// Optional end-of-packet flush with a lane mask: GEARBOX_1_TO_N_LAST_EN.
module gearbox_1_to_n
    import gearbox_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    gearbox_1_to_n_if.slave bus
);

    localparam int CNT_W  = cnt_width(N);
    localparam int BEAT_W = N * WIDTH;
    localparam int ACC_W  = (N - 1) * WIDTH;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(N - 1);

    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic              up_rdy;
    logic              up_xfer;
    logic              beat_done;
    logic [BEAT_W-1:0] lanes;
    logic [BEAT_W-1:0] beat;
`ifdef GEARBOX_1_TO_N_LAST_EN
    logic [N-1:0]      beat_keep;
`endif

    assign up_xfer    = bus.up_vld & up_rdy;
    assign bus.up_rdy = up_rdy;
    assign lanes      = {acc, bus.up_data};

`ifdef GEARBOX_1_TO_N_LAST_EN
    assign beat_done = up_xfer & ((cnt == LAST_LANE) | bus.up_last);
    assign beat_keep = N'(lane_mask(int'(cnt), N));
`else
    assign beat_done = up_xfer & (cnt == LAST_LANE);
`endif

    // Assemble the outgoing beat: filled lanes from acc, the closing word in lane cnt, zeros after it.
    always_comb begin
        beat = '0;
        for (int k = 0; k < N; k++) begin
            if (k == int'(cnt)) begin
                beat[(N-k)*WIDTH-1 -: WIDTH] = bus.up_data;
            end else if (k < int'(cnt)) begin
                beat[(N-k)*WIDTH-1 -: WIDTH] = lanes[(N-k)*WIDTH-1 -: WIDTH];
            end
        end
    end

    // Accumulate words into their lanes. A finished beat empties acc so nothing stale carries over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (up_xfer) begin
            if (beat_done) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                for (int k = 0; k < N - 1; k++) begin
                    if (cnt == CNT_W'(k)) begin
                        acc[(N-1-k)*WIDTH-1 -: WIDTH] <= bus.up_data;
                    end
                end
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    gearbox_out_reg #(
        .DATA_W (BEAT_W),
        .KEEP_W (N)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (beat_done),
        .load_data (beat),
`ifdef GEARBOX_1_TO_N_LAST_EN
        .load_keep (beat_keep),
        .keep      (bus.down_keep),
`endif
        .rdy       (bus.down_rdy),
        .vld       (bus.down_vld),
        .data      (bus.down_data),
        .up_rdy    (up_rdy)
    );

endmodule

// File: tb/tb_gearbox_1_to_n.sv
// Directed and lightly randomised bench for gearbox_1_to_n (WIDTH=8, N=4).
// Inputs change 1 time unit after posedge. Outputs are sampled on negedge.
module tb_gearbox_1_to_n;

    localparam int W  = 8;
    localparam int NL = 4;
    localparam int BW = W * NL;

    logic clk;
    logic rst_n;

    gearbox_1_to_n_if #(.WIDTH(W), .N(NL)) bus ();

    gearbox_1_to_n #(.WIDTH(W), .N(NL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [BW-1:0] exp_q[$];
    logic [NL-1:0] exp_keep_q[$];
    int            beat_cyc[$];
    int            n_cmp  = 0;
    int            n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [BW-1:0] d, input logic [NL-1:0] k);
        exp_q.push_back(d);
        exp_keep_q.push_back(k);
    endtask

    // Pop and compare every beat that will transfer on the next posedge.
    always @(negedge clk) begin
        if (rst_n && bus.down_vld && bus.down_rdy) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_beat: observed %0h expected none", bus.down_data);
            end
            if (exp_q.size() != 0) begin
                logic [BW-1:0] e;
                logic [NL-1:0] ek;
                e  = exp_q.pop_front();
                ek = exp_keep_q.pop_front();
                check("beat_data", 64'(bus.down_data), 64'(e));
`ifdef GEARBOX_1_TO_N_LAST_EN
                check("beat_keep", 64'(bus.down_keep), 64'(ek));
`else
                if (ek != '1) $display("note: partial keep expected without last support");
`endif
                beat_cyc.push_back(cyc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Offer one word and hold it until accepted. waited = cycles offered.
    task automatic send_word(input logic [W-1:0] d, input logic last, output int waited);
        logic acc_now;
        bit   ok;
        ok = 0;
        waited = 0;
        bus.up_vld  = 1'b1;
        bus.up_data = d;
`ifdef GEARBOX_1_TO_N_LAST_EN
        bus.up_last = last;
`else
        if (last) $display("note: up_last ignored in this build");
`endif
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            acc_now = bus.up_rdy;
            @(posedge clk);
            #1;
            waited++;
            if (acc_now) begin
                ok = 1;
                break;
            end
        end
        bus.up_vld = 1'b0;
`ifdef GEARBOX_1_TO_N_LAST_EN
        bus.up_last = 1'b0;
`endif
        check("send_accepted", 64'(ok), 64'(1));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0) break;
            idle(1);
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int            w;
        logic [W-1:0]  rw[NL];
        logic [BW-1:0] stall_beat;

        rst_n        = 1'b0;
        bus.up_vld   = 1'b0;
        bus.up_data  = '0;
        bus.down_rdy = 1'b1;
`ifdef GEARBOX_1_TO_N_LAST_EN
        bus.up_last  = 1'b0;
`endif

        // Reset values
        idle(3);
        check("rst_down_vld", 64'(bus.down_vld), 64'(0));
        check("rst_down_data", 64'(bus.down_data), 64'(0));
`ifdef GEARBOX_1_TO_N_LAST_EN
        check("rst_down_keep", 64'(bus.down_keep), 64'(0));
`endif
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_up_rdy", 64'(bus.up_rdy), 64'(1));
        idle(1);

        // 1) Single beat and one-cycle latency
        push_exp(32'hA0A1A2A3, 4'b1111);
        send_word(8'hA0, 1'b0, w);
        send_word(8'hA1, 1'b0, w);
        send_word(8'hA2, 1'b0, w);
        check("t1_vld_before_last", 64'(bus.down_vld), 64'(0));
        send_word(8'hA3, 1'b0, w);
        check("t1_vld_latency", 64'(bus.down_vld), 64'(1));
        check("t1_data_latency", 64'(bus.down_data), 64'h00000000A0A1A2A3);
`ifdef GEARBOX_1_TO_N_LAST_EN
        check("t1_keep", 64'(bus.down_keep), 64'(4'b1111));
`endif
        drain();

        // 2) Back-to-back words: no upstream bubbles, beats every 4 cycles
        beat_cyc.delete();
        push_exp(32'h00010203, 4'b1111);
        push_exp(32'h04050607, 4'b1111);
        push_exp(32'h08090A0B, 4'b1111);
        for (int i = 0; i < 12; i++) begin
            send_word(W'(i), 1'b0, w);
            check("t2_no_bubble", 64'(w), 64'(1));
        end
        drain();
        check("t2_beat_count", 64'(beat_cyc.size()), 64'(3));
        if (beat_cyc.size() == 3) begin
            check("t2_spacing_a", 64'(beat_cyc[1] - beat_cyc[0]), 64'(4));
            check("t2_spacing_b", 64'(beat_cyc[2] - beat_cyc[1]), 64'(4));
        end

        // 3) Stall with a pending beat, then release
        bus.down_rdy = 1'b0;
        stall_beat   = 32'hB0B1B2B3;
        push_exp(stall_beat, 4'b1111);
        push_exp(32'hC0C1C2C3, 4'b1111);
        send_word(8'hB0, 1'b0, w);
        send_word(8'hB1, 1'b0, w);
        send_word(8'hB2, 1'b0, w);
        send_word(8'hB3, 1'b0, w);
        bus.up_vld  = 1'b1;
        bus.up_data = 8'hC0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_stall_up_rdy", 64'(bus.up_rdy), 64'(0));
            check("t3_stall_vld", 64'(bus.down_vld), 64'(1));
            check("t3_stall_data", 64'(bus.down_data), 64'(stall_beat));
            idle(1);
        end
        bus.down_rdy = 1'b1;
        send_word(8'hC0, 1'b0, w);
        check("t3_resume_same_cycle", 64'(w), 64'(1));
        send_word(8'hC1, 1'b0, w);
        send_word(8'hC2, 1'b0, w);
        send_word(8'hC3, 1'b0, w);
        drain();

        // 4) Idle cycles between words (garbage data while up_vld=0)
        push_exp(32'h11223344, 4'b1111);
        send_word(8'h11, 1'b0, w);
        bus.up_data = 8'hEE; idle(1);
        send_word(8'h22, 1'b0, w);
        bus.up_data = 8'hEE; idle(1);
        send_word(8'h33, 1'b0, w);
        bus.up_data = 8'hEE; idle(1);
        check("t4_no_early_beat", 64'(bus.down_vld), 64'(0));
        send_word(8'h44, 1'b0, w);
        drain();

        // 5a) Reset while a beat is held
        bus.down_rdy = 1'b0;
        send_word(8'hF0, 1'b0, w);
        send_word(8'hF1, 1'b0, w);
        send_word(8'hF2, 1'b0, w);
        send_word(8'hF3, 1'b0, w);
        rst_n = 1'b0;
        #1;
        check("t5_rst_vld", 64'(bus.down_vld), 64'(0));
        check("t5_rst_data", 64'(bus.down_data), 64'(0));
        check("t5_rst_up_rdy", 64'(bus.up_rdy), 64'(1));
        idle(1);
        rst_n        = 1'b1;
        bus.down_rdy = 1'b1;
        idle(1);

        // 5b) Reset mid-beat; partial words must vanish
        send_word(8'h55, 1'b0, w);
        send_word(8'h66, 1'b0, w);
        rst_n = 1'b0;
        #1;
        check("t5b_rst_vld", 64'(bus.down_vld), 64'(0));
        idle(1);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5b_up_rdy_after_release", 64'(bus.up_rdy), 64'(1));
        idle(1);
        push_exp(32'hAABBCCDD, 4'b1111);
        send_word(8'hAA, 1'b0, w);
        send_word(8'hBB, 1'b0, w);
        send_word(8'hCC, 1'b0, w);
        send_word(8'hDD, 1'b0, w);
        drain();

        // 6) Random words with random gaps
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < NL; k++) rw[k] = W'($urandom_range(0, 255));
            push_exp({rw[0], rw[1], rw[2], rw[3]}, 4'b1111);
            for (int k = 0; k < NL; k++) begin
                send_word(rw[k], 1'b0, w);
                idle($urandom_range(0, 2));
            end
        end
        drain();

`ifdef GEARBOX_1_TO_N_LAST_EN
        // 7) Early end of packet, then a normal full beat
        push_exp(32'h01020000, 4'b1100);
        push_exp(32'h03040506, 4'b1111);
        send_word(8'h01, 1'b0, w);
        send_word(8'h02, 1'b1, w);
        check("t7_partial_vld", 64'(bus.down_vld), 64'(1));
        send_word(8'h03, 1'b0, w);
        send_word(8'h04, 1'b0, w);
        send_word(8'h05, 1'b0, w);
        send_word(8'h06, 1'b1, w);
        drain();
`endif

        idle(4);
        check("final_queue_empty", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
